// File: rtl/out_bcd_seq_if.sv
// Output-stage bus: CPU OUT strobe and value in, BCD digits and status out.
interface out_bcd_seq_if #(parameter int DATA_W = 32);
  logic              out_en;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              valid;
  logic              overflow;
  logic [3:0]        mil;
  logic [3:0]        cent;
  logic [3:0]        dez;
  logic [3:0]        uni;

  modport master (output out_en, value,
                  input  busy, valid, overflow, mil, cent, dez, uni);
  modport slave  (input  out_en, value,
                  output busy, valid, overflow, mil, cent, dez, uni);
endinterface

// File: rtl/out_bcd_seq.sv
// Sequential binary-to-BCD output stage: clamp to 4 digits, iterative double-dabble,
// commit digits once per conversion with a one-deep latest-wins request buffer.
module out_bcd_seq #(
  parameter int DATA_W  = 32,
  parameter int MAX_VAL = 9999,
  parameter int NBITS   = 14
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  out_bcd_seq_if.slave  bus
);
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic              out_en_q, strobe;
  logic              ld_ovf;
  logic [NBITS-1:0]  ld_val;
  logic [NBITS-1:0]  bin;
  logic [15:0]       acc, acc_adj;
  logic [CW-1:0]     cnt;
  logic              ovf_r;
  logic              pend, pend_ovf;
  logic [NBITS-1:0]  pend_val;
  logic              load_cur, load_pnd, shift_en, commit;
  logic              valid_r, overflow_r;
  logic [15:0]       digits;

  assign strobe = bus.out_en & ~out_en_q;
  assign ld_ovf = bus.value > DATA_W'(MAX_VAL);
  assign ld_val = ld_ovf ? NBITS'(MAX_VAL) : bus.value[NBITS-1:0];

  // Add-3 correction per BCD digit ahead of each shift.
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3
                                                        : acc[4*i +: 4];
  end

  always_comb begin
    state_nxt = state;
    load_cur  = 1'b0;
    load_pnd  = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (strobe) begin
        load_cur  = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        commit = 1'b1;
        if (strobe) begin
          load_cur  = 1'b1;
          state_nxt = SHIFT;
        end else if (pend) begin
          load_pnd  = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      out_en_q   <= 1'b0;
      bin        <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_r      <= 1'b0;
      pend       <= 1'b0;
      pend_val   <= '0;
      pend_ovf   <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      digits     <= '0;
    end else begin
      state    <= state_nxt;
      out_en_q <= bus.out_en;
      valid_r  <= commit;
      if (load_cur) begin
        bin   <= ld_val;
        acc   <= '0;
        ovf_r <= ld_ovf;
        cnt   <= '0;
      end else if (load_pnd) begin
        bin   <= pend_val;
        acc   <= '0;
        ovf_r <= pend_ovf;
        cnt   <= '0;
      end else if (shift_en) begin
        {acc, bin} <= {acc_adj, bin} << 1;
        cnt        <= cnt + 1'b1;
      end
      if (commit) begin
        digits     <= acc;
        overflow_r <= ovf_r;
      end
      // A request arriving mid-conversion replaces any older pending one.
      if (state == SHIFT && strobe) begin
        pend     <= 1'b1;
        pend_val <= ld_val;
        pend_ovf <= ld_ovf;
      end else if (state == DONE) begin
        pend <= 1'b0;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.valid    = valid_r;
  assign bus.overflow = overflow_r;
  assign bus.mil      = digits[15:12];
  assign bus.cent     = digits[11:8];
  assign bus.dez      = digits[7:4];
  assign bus.uni      = digits[3:0];
endmodule

// File: tb/tb_out_bcd_seq.sv
// Directed bench for out_bcd_seq: vector table plus hand sequences for the
// pending-request, held-level, and mid-conversion reset cases.
module tb_out_bcd_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  out_bcd_seq_if #(.DATA_W(32)) bus ();

  out_bcd_seq #(.DATA_W(32), .MAX_VAL(9999), .NBITS(14)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [15:0] digits;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] cur_digits();
    return {bus.mil, bus.cent, bus.dez, bus.uni};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raise out_en so that the next rising edge is the strobe edge; return 1 after it.
  task automatic strobe(input logic [31:0] v);
    @(negedge clk);
    bus.value  = v;
    bus.out_en = 1'b1;
    @(posedge clk);
    #1;
    bus.out_en = 1'b0;
  endtask

  // Step at least one edge, then until valid; count edges, busy-low and digit changes before valid.
  task automatic wait_valid(output int k, output int lows, output int changes);
    logic [15:0] prev;
    prev    = cur_digits();
    k       = 0;
    lows    = 0;
    changes = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!bus.valid) begin
        if (!bus.busy) lows++;
        if (cur_digits() !== prev) changes++;
      end
    end while (!bus.valid && k < 60);
  endtask

  initial begin
    int k, lows, changes, nvalid;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'd1234,       16'h1234, 1'b0};
    vecs[1] = '{32'd0,          16'h0000, 1'b0};
    vecs[2] = '{32'd9999,       16'h9999, 1'b0};
    vecs[3] = '{32'd10000,      16'h9999, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF,  16'h9999, 1'b1};
    vecs[5] = '{32'd1234,       16'h1234, 1'b0};
    vecs[6] = '{32'd9,          16'h0009, 1'b0};
    vecs[7] = '{32'd1090,       16'h1090, 1'b0};

    reset      = 1'b1;
    bus.out_en = 1'b0;
    bus.value  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_valid",  32'(bus.valid), 32'd0);
    chk("rst_ovf",    32'(bus.overflow), 32'd0);
    chk("rst_digits", 32'(cur_digits()), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].v);
      chk($sformatf("v%0d_busy_edge0", i), 32'(bus.busy), 32'd1);
      wait_valid(k, lows, changes);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'd15);
      chk($sformatf("v%0d_busy_gap", i), 32'(lows), 32'd0);
      chk($sformatf("v%0d_early_digits", i), 32'(changes), 32'd0);
      chk($sformatf("v%0d_digits", i), 32'(cur_digits()), 32'(vecs[i].digits));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_busy_done", i), 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid_pulse", i), 32'(bus.valid), 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(cur_digits()), 32'(vecs[i].digits));
    end

    // Pending requests: 42 at edge 0, 7 at edge 5, 8 at edge 9; 7 is superseded.
    repeat (2) @(posedge clk);
    strobe(32'd42);
    repeat (4) @(posedge clk);
    strobe(32'd7);
    repeat (3) @(posedge clk);
    strobe(32'd8);
    wait_valid(k, lows, changes);
    chk("pend_lat1",    32'(k), 32'd6);
    chk("pend_gap1",    32'(lows), 32'd0);
    chk("pend_digits1", 32'(cur_digits()), 32'h0042);
    chk("pend_busy15",  32'(bus.busy), 32'd1);
    wait_valid(k, lows, changes);
    chk("pend_lat2",    32'(k), 32'd15);
    chk("pend_gap2",    32'(lows), 32'd0);
    chk("pend_early2",  32'(changes), 32'd0);
    chk("pend_digits2", 32'(cur_digits()), 32'h0008);
    chk("pend_busy30",  32'(bus.busy), 32'd0);

    // Held level: only one rising edge, so only one conversion.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.value  = 32'd77;
    bus.out_en = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid) nvalid++;
    end
    bus.out_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid) nvalid++;
    end
    chk("held_valids", 32'(nvalid), 32'd1);
    chk("held_digits", 32'(cur_digits()), 32'h0077);
    chk("held_idle",   32'(bus.busy), 32'd0);

    // Reset mid-conversion: abort, clear outputs, no valid afterwards.
    strobe(32'd555);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_digits", 32'(cur_digits()), 32'h0);
    chk("abort_busy",   32'(bus.busy), 32'd0);
    chk("abort_valid",  32'(bus.valid), 32'd0);
    nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid || bus.busy) nvalid++;
    end
    chk("abort_quiet", 32'(nvalid), 32'd0);
    strobe(32'd321);
    wait_valid(k, lows, changes);
    chk("after_lat",    32'(k), 32'd15);
    chk("after_digits", 32'(cur_digits()), 32'h0321);
    chk("after_ovf",    32'(bus.overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
